// File: rtl/modd_arbiter.sv
// Round-robin arbiter in front of one shared minimum-image displacement
// (modd) datapath. A granted request is latched, then x, y and z are pushed
// through the single modd unit on consecutive axis states. The 3D result is
// returned with the requester id over a valid/ready handshake.
// Build option MODD_ARB_PIPE_EN: registers the modd output, so each axis
// state lasts two cycles.
//
// state  | meaning
// IDLE   | arbitrate; req_ready asserted to the winner, request latched on the edge
// CALC_X | modd on x components, result into resp_d[31:0]
// CALC_Y | modd on y components, result into resp_d[63:32]
// CALC_Z | modd on z components, result into resp_d[95:64]
// DONE   | resp_valid high, result held until resp_ready
module modd_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*96-1:0] req_a,
   input  logic [NREQ*96-1:0] req_b,
   input  logic [95:0]        box_m,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [IDW-1:0]     resp_id,
   output logic [95:0]        resp_d
);

   typedef enum logic [2:0] {IDLE, CALC_X, CALC_Y, CALC_Z, DONE} state_t;

   state_t         state, state_nx;
   logic [IDW-1:0] rr_ptr, grant;
   logic           found;
   logic [95:0]    a_q, b_q, m_q;
   logic [1:0]     axis;
   logic [31:0]    modd_out, wr_data;
   logic           wr_axis, step;

   // fp32 add, round-to-nearest-even; results below the normal range flush
   // to signed zero (the operands this block sees are positions and box
   // sizes, far from the subnormal range).
   function automatic logic [31:0] fp_add(input logic [31:0] p, input logic [31:0] q);
      logic [31:0] x, y;
      logic [7:0]  ex, ey, sh;
      logic [26:0] mx, my, ms, m;
      logic [27:0] s;
      logic [24:0] mr;
      logic [9:0]  e, lz;
      logic        hit, uf;
      // larger magnitude first, so the result always carries x's sign
      if (p[30:0] >= q[30:0]) begin x = p; y = q; end
      else begin x = q; y = p; end
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
      my = {y[30:23] != 8'd0, y[22:0], 3'b000};
      sh = ex - ey;
      if (sh > 8'd26) ms = {26'd0, |my};
      else begin
         ms    = my >> sh;
         ms[0] = ms[0] | (|(my & ~({27{1'b1}} << sh)));
      end
      if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, ms};
      else                s = {1'b0, mx} - {1'b0, ms};
      lz  = 10'd0;
      hit = 1'b0;
      for (int i = 27; i >= 0; i--) begin
         if (!hit) begin
            if (s[i]) hit = 1'b1;
            else      lz  = lz + 10'd1;
         end
      end
      m  = '0;
      e  = '0;
      uf = 1'b0;
      if (s[27]) begin
         m = s[27:1] | {26'd0, s[0]};
         e = {2'b00, ex} + 10'd1;
      end else begin
         m  = s[26:0] << (lz - 10'd1);
         uf = ({2'b00, ex} + 10'd1) <= lz;
         e  = {2'b00, ex} + 10'd1 - lz;
      end
      mr = {1'b0, m[26:3]} + {24'd0, m[2] & (m[1] | m[0] | m[3])};
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 10'd1;
      end
      // exact cancellation gives +0
      if (s == 28'd0)          fp_add = 32'd0;
      else if (uf)             fp_add = {x[31], 31'd0};
      else if (e >= 10'd255)   fp_add = {x[31], 8'hFF, 23'd0};
      else                     fp_add = {x[31], e[7:0], mr[22:0]};
   endfunction

   // Smallest-magnitude candidate of (b-a)-M, b-a, (b-a)+M. On equal
   // magnitudes the unwrapped b-a wins, then (b-a)-M.
   function automatic logic [31:0] modd(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] m);
      logic [31:0] d, lo, hi, r;
      d  = fp_add(b, {~a[31], a[30:0]});
      lo = fp_add(d, {~m[31], m[30:0]});
      hi = fp_add(d, m);
      r  = d;
      if (lo[30:0] < r[30:0]) r = lo;
      if (hi[30:0] < r[30:0]) r = hi;
      return r;
   endfunction

   // round-robin search upward from the requester after the last winner
   always_comb begin : arb
      int idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && req_valid[IDW'(idx)]) begin
            found = 1'b1;
            grant = IDW'(idx);
         end
      end
   end

   // axis select and the shared modd unit
   always_comb begin
      axis = 2'd0;
      case (state)
         CALC_Y:  axis = 2'd1;
         CALC_Z:  axis = 2'd2;
         default: axis = 2'd0;
      endcase
      modd_out = modd(a_q[32*axis +: 32], b_q[32*axis +: 32], m_q[32*axis +: 32]);
   end

`ifdef MODD_ARB_PIPE_EN
   logic        cnt;
   logic [31:0] modd_q;

   // modd output register and per-axis two-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= 1'b0;
         modd_q <= '0;
      end else begin
         modd_q <= modd_out;
         cnt    <= (state == CALC_X || state == CALC_Y || state == CALC_Z) ? ~cnt : 1'b0;
      end
   end

   assign step    = cnt;
   assign wr_data = modd_q;
`else
   assign step    = 1'b1;
   assign wr_data = modd_out;
`endif

   // next state, grant strobe and axis write enable
   always_comb begin
      state_nx  = state;
      req_ready = '0;
      wr_axis   = 1'b0;
      case (state)
         IDLE: if (found) begin
            req_ready[grant] = 1'b1;
            state_nx         = CALC_X;
         end
         CALC_X: if (step) begin wr_axis = 1'b1; state_nx = CALC_Y; end
         CALC_Y: if (step) begin wr_axis = 1'b1; state_nx = CALC_Z; end
         CALC_Z: if (step) begin wr_axis = 1'b1; state_nx = DONE;   end
         DONE:   if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign resp_valid = (state == DONE);

   // state, pointer, operand latches and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= IDW'(NREQ - 1);
         resp_id <= '0;
         resp_d  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && found) begin
            rr_ptr  <= grant;
            resp_id <= grant;
            a_q     <= req_a[96*grant +: 96];
            b_q     <= req_b[96*grant +: 96];
            m_q     <= box_m;
         end
         if (wr_axis) resp_d[32*axis +: 32] <= wr_data;
      end
   end

endmodule
